// File: rtl/divide_4bit_seq_if.sv
// Start/done handshake bundle between a requester and the 4-bit sequential divider.
interface divide_4bit_seq_if;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       busy;
  logic       done;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, div_by_zero, busy, done
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, div_by_zero, busy, done
  );
endinterface

// File: rtl/divide_4bit_seq.sv
// Unsigned 4-bit restoring divider: one trial subtract/restore step per clock,
// four cycles per divide, start/done handshake with busy while iterating.
module divide_4bit_seq (
  input  logic                 clk,
  input  logic                 rst_n,
  divide_4bit_seq_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] p_q, p_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] div_q, div_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;

  logic [4:0] trial_t;
  logic [4:0] trial;
  logic [3:0] p_step;
  logic [3:0] acc_step;

  // One restoring step: shift the next dividend bit into P and try to subtract D.
  always_comb begin
    trial_t = {p_q, acc_q[3]};
    trial   = trial_t - {1'b0, div_q};
    if (!trial[4]) begin
      p_step   = trial[3:0];
      acc_step = {acc_q[2:0], 1'b1};
    end else begin
      p_step   = trial_t[3:0];
      acc_step = {acc_q[2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= 4'd0;
      acc_q   <= 4'd0;
      div_q   <= 4'd0;
      cnt_q   <= 2'd0;
      quot_q  <= 4'd0;
      rem_q   <= 4'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    acc_d   = acc_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      RUN: begin
        p_d   = p_step;
        acc_d = acc_step;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) begin
          quot_d  = acc_step;
          rem_d   = p_step;
          state_d = DONE;
        end
      end
      default: begin
        if (bus.start) begin
          if (bus.divisor != 4'd0) begin
            p_d     = 4'd0;
            acc_d   = bus.dividend;
            div_d   = bus.divisor;
            cnt_d   = 2'd3;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            // Zero divisor completes on the accepting edge with saturated quotient.
            quot_d  = 4'hF;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    bus.busy        = (state_q == RUN);
    bus.done        = (state_q == DONE);
    bus.quotient    = quot_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_divide_4bit_seq.sv
// Randomized and directed checks of divide_4bit_seq against plain / and % arithmetic.
module tb_divide_4bit_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  divide_4bit_seq_if bus ();

  divide_4bit_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: arithmetic division, saturated quotient for a zero divisor.
  function automatic logic [3:0] ref_q(input logic [3:0] a, input logic [3:0] b);
    return (b == 4'd0) ? 4'hF : 4'(a / b);
  endfunction

  function automatic logic [3:0] ref_r(input logic [3:0] a, input logic [3:0] b);
    return (b == 4'd0) ? a : 4'(a % b);
  endfunction

  // Waits after the accepting edge for done; returns latency and busy cycle count.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (!bus.done && lat < 12) begin
      if (bus.busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input string tag);
    int lat, bc;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.dividend = 4'($urandom); bus.divisor = 4'($urandom);
    wait_done(lat, bc);
    check({tag, " latency"}, lat, (b == 4'd0) ? 0 : 4);
    check({tag, " busy cycles"}, bc, (b == 4'd0) ? 0 : 4);
    check({tag, " busy&done"}, bus.busy & bus.done, 0);
    check({tag, " quotient"}, bus.quotient, ref_q(a, b));
    check({tag, " remainder"}, bus.remainder, ref_r(a, b));
    check({tag, " div_by_zero"}, bus.div_by_zero, b == 4'd0);
    $display("op %0d/%0d -> q=%0d r=%0d dbz=%0b lat=%0d", a, b, bus.quotient,
             bus.remainder, bus.div_by_zero, lat);
    @(posedge clk); #1;
    check({tag, " done pulse width"}, bus.done, 0);
    check({tag, " quotient held"}, bus.quotient, ref_q(a, b));
  endtask

  initial begin
    int lat, bc, dones;
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.dividend = 4'd0; bus.divisor = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset quotient", bus.quotient, 0);
    check("reset remainder", bus.remainder, 0);
    check("reset dbz", bus.div_by_zero, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op(4'd13, 4'd3, "basic 13/3");
    run_op(4'd15, 4'd1, "15/1");
    run_op(4'd2, 4'd7, "2/7");
    run_op(4'd0, 4'd5, "0/5");
    run_op(4'd15, 4'd15, "15/15");
    run_op(4'd9, 4'd0, "9/0");
    run_op(4'd6, 4'd4, "6/4 after zero");

    // Start pulse during RUN must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd7; bus.divisor = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        check("busy-start quotient", bus.quotient, 2);
        check("busy-start remainder", bus.remainder, 2);
      end
    end
    check("busy-start done count", dones, 1);
    $display("start-during-busy: %0d done pulse(s), q=%0d r=%0d", dones, bus.quotient, bus.remainder);

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd10; bus.divisor = 4'd3;
    @(posedge clk); #1;
    wait_done(lat, bc);
    check("b2b first latency", lat, 4);
    check("b2b first quotient", bus.quotient, 3);
    check("b2b first remainder", bus.remainder, 1);
    @(negedge clk);
    bus.dividend = 4'd14; bus.divisor = 4'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b done falls", bus.done, 0);
    check("b2b busy", bus.busy, 1);
    check("b2b quotient held", bus.quotient, 3);
    wait_done(lat, bc);
    check("b2b second latency", lat, 4);
    check("b2b second quotient", bus.quotient, 3);
    check("b2b second remainder", bus.remainder, 2);
    $display("back-to-back: second q=%0d r=%0d", bus.quotient, bus.remainder);
    @(posedge clk); #1;

    // Asynchronous reset mid-run.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd11; bus.divisor = 4'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst busy", bus.busy, 0);
    check("midrst done", bus.done, 0);
    check("midrst quotient", bus.quotient, 0);
    check("midrst remainder", bus.remainder, 0);
    check("midrst dbz", bus.div_by_zero, 0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("midrst no done", dones, 0);
    @(negedge clk); rst_n = 1'b1;
    $display("reset mid-run: outputs cleared");
    run_op(4'd11, 4'd2, "11/2 after reset");

    // Full sweep of every non-zero divisor.
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        run_op(4'(a), 4'(b), "sweep");

    // Random operations, zero divisors included.
    for (int i = 0; i < 40; i++)
      run_op(4'($urandom), 4'($urandom_range(0, 15)), "random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
